fifo_wr_rr_arb: RTL and testbench

- Round-robin arbiter that shares one synchronous-FIFO write port among NumReq requesters.
- Registers the winning beat into a single output holding stage and presents it with a valid/ready handshake toward the FIFO write side.
- Sequences FIFO flushes: stops granting, drains the held beat, pulses the FIFO clear, then reports completion.
- Sits between the UART TX producers (CSR write path, DMA-style feeders) and the TX sync FIFO and its pointer logic.

---
 rtl/fifo_wr_rr_arb.sv | 154 +++++++++++++++
 tb/tb_fifo_wr_rr_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_rr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NumReq requesters, with a flush sequencer.
// Optional macro FIFO_ARB_RESERVE_EN keeps Reserve FIFO slots available only to requester 0.
module fifo_wr_rr_arb #(
  parameter int NumReq  = 4,
  parameter int Width   = 8,
  parameter int Depth   = 4,
  parameter int Reserve = 1,
  localparam int DepthW = $clog2(Depth + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq*Width-1:0] data_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic                    fifo_wvalid_o,
  output logic [Width-1:0]        fifo_wdata_o,
  input  logic                    fifo_wready_i,
  input  logic [DepthW-1:0]       fifo_depth_i,
  input  logic                    flush_req_i,
  output logic                    fifo_clr_o,
  output logic                    flush_done_o,
  output logic                    busy_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {StIdle, StDrain, StClr, StDone} state_e;

  state_e            state_q;
  logic              pending_q;
  logic              clr_q;
  logic              done_q;
  logic              wvalid_q, wvalid_d;
  logic [Width-1:0]  wdata_q, wdata_d;
  logic [IdxW-1:0]   lastGnt_q, lastGnt_d;

  logic [NumReq-1:0] eligible;
  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   cand;
  logic              found;
  logic              canLoad;
  logic              grant;
  logic [Width-1:0]  selData;

`ifdef FIFO_ARB_RESERVE_EN
  // Occupancy counts the beat already in the holding stage, since it is committed to the FIFO.
  logic [DepthW:0] occupancy;
  logic            roomForOthers;

  assign occupancy     = {1'b0, fifo_depth_i} + {{DepthW{1'b0}}, wvalid_q};
  assign roomForOthers = occupancy < (DepthW+1)'(Depth - Reserve);

  always_comb begin
    eligible    = req_i;
    eligible[0] = req_i[0];
    for (int i = 1; i < NumReq; i++) begin
      eligible[i] = req_i[i] & roomForOthers;
    end
  end
`else
  logic unusedDepth;

  assign eligible    = req_i;
  assign unusedDepth = (^fifo_depth_i) ^ (Reserve < Depth);
`endif

  always_comb begin
    winner = lastGnt_q;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = IdxW'((int'(lastGnt_q) + k) % NumReq);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign canLoad = !wvalid_q || fifo_wready_i;
  // A flush request in IDLE takes precedence over any pending grant.
  assign grant   = (state_q == StIdle) && !flush_req_i && !pending_q && canLoad && found && !rst_i;
  assign gnt_o   = grant ? (NumReq'(1) << winner) : '0;
  assign selData = data_i[winner*Width +: Width];

  always_comb begin
    wvalid_d  = wvalid_q;
    wdata_d   = wdata_q;
    lastGnt_d = lastGnt_q;
    if (grant) begin
      wvalid_d  = 1'b1;
      wdata_d   = selData;
      lastGnt_d = winner;
    end else if (wvalid_q && fifo_wready_i) begin
      wvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      lastGnt_q <= IdxW'(NumReq - 1);
    end else begin
      wvalid_q  <= wvalid_d;
      wdata_q   <= wdata_d;
      lastGnt_q <= lastGnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (flush_req_i || pending_q) begin
            state_q   <= StDrain;
            pending_q <= 1'b0;
          end
        end
        StDrain: begin
          pending_q <= pending_q | flush_req_i;
          if (!wvalid_q || fifo_wready_i) begin
            state_q <= StClr;
            clr_q   <= 1'b1;
          end
        end
        StClr: begin
          pending_q <= pending_q | flush_req_i;
          state_q   <= StDone;
          done_q    <= 1'b1;
        end
        StDone: begin
          pending_q <= pending_q | flush_req_i;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fifo_wvalid_o = wvalid_q;
  assign fifo_wdata_o  = wdata_q;
  assign fifo_clr_o    = clr_q;
  assign flush_done_o  = done_q;
  assign busy_o        = (state_q != StIdle) || wvalid_q;

endmodule

// File: tb/tb_fifo_wr_rr_arb.sv
// Scoreboard bench for fifo_wr_rr_arb: reference model predicts grants, flush pulses and the beat order.
module tb_fifo_wr_rr_arb;

  localparam int NumReq  = 4;
  localparam int Width   = 8;
  localparam int Depth   = 4;
  localparam int Reserve = 1;
  localparam int DepthW  = $clog2(Depth + 1);

  logic                    clk;
  logic                    rstIn;
  logic [NumReq-1:0]       reqIn;
  logic [NumReq*Width-1:0] dataIn;
  logic [NumReq-1:0]       gntOut;
  logic                    wvalidOut;
  logic [Width-1:0]        wdataOut;
  logic                    wreadyIn;
  logic [DepthW-1:0]       depthIn;
  logic                    flushIn;
  logic                    clrOut;
  logic                    doneOut;
  logic                    busyOut;

  fifo_wr_rr_arb #(
    .NumReq(NumReq), .Width(Width), .Depth(Depth), .Reserve(Reserve)
  ) dut (
    .clk_i(clk),
    .rst_i(rstIn),
    .req_i(reqIn),
    .data_i(dataIn),
    .gnt_o(gntOut),
    .fifo_wvalid_o(wvalidOut),
    .fifo_wdata_o(wdataOut),
    .fifo_wready_i(wreadyIn),
    .fifo_depth_i(depthIn),
    .flush_req_i(flushIn),
    .fifo_clr_o(clrOut),
    .flush_done_o(doneOut),
    .busy_o(busyOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: who holds priority, whether a beat is parked, and where the flush sequence is.
  logic [Width-1:0] reqData [NumReq];
  logic [Width-1:0] expQ [$];
  int  mLast;
  int  mPhase;
  bit  mHeld;
  bit  mPend;
  int  grantedIdx;
  int  clrCount;
  bit  reqActive [NumReq];

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelEligible(input int c, input int depth);
`ifdef FIFO_ARB_RESERVE_EN
    return (c == 0) || ((depth + int'(mHeld)) < (Depth - Reserve));
`else
    return 1'b1;
`endif
  endfunction

  function automatic int modelGrant(input logic [NumReq-1:0] req, input bit wready,
                                    input bit flush, input bit reset, input int depth);
    if (reset || mPhase != 0 || flush || mPend || (mHeld && !wready)) return -1;
    for (int k = 1; k <= NumReq; k++) begin
      int c;
      c = (mLast + k) % NumReq;
      if (req[c] && modelEligible(c, depth)) return c;
    end
    return -1;
  endfunction

  task automatic checkOutput(input int gIdx);
    logic [NumReq-1:0] expGnt;
    expGnt = '0;
    if (gIdx >= 0) expGnt[gIdx] = 1'b1;
    checkField("gnt", 32'(gntOut), 32'(expGnt));
    checkField("wvalid", 32'(wvalidOut), 32'(mHeld));
    checkField("clr", 32'(clrOut), 32'(mPhase == 2));
    checkField("done", 32'(doneOut), 32'(mPhase == 3));
    checkField("busy", 32'(busyOut), 32'((mPhase != 0) || mHeld));
  endtask

  task automatic advanceModel(input int gIdx, input bit wready, input bit flush, input bit reset);
    bit oldHeld;
    if (reset) begin
      mHeld  = 1'b0;
      mPhase = 0;
      mPend  = 1'b0;
      mLast  = NumReq - 1;
      expQ.delete();
      return;
    end
    oldHeld = mHeld;
    if (gIdx >= 0) begin
      mHeld = 1'b1;
      mLast = gIdx;
      expQ.push_back(reqData[gIdx]);
    end else if (mHeld && wready) begin
      mHeld = 1'b0;
    end
    case (mPhase)
      0: if (flush || mPend) begin mPhase = 1; mPend = 1'b0; end
      1: begin mPend = mPend | flush; if (!oldHeld || wready) mPhase = 2; end
      2: begin mPend = mPend | flush; mPhase = 3; end
      default: begin mPend = mPend | flush; mPhase = 0; end
    endcase
  endtask

  task automatic applyStimulus(input logic [NumReq-1:0] req, input bit wready,
                               input bit flush, input bit reset, input int depth);
    @(negedge clk);
    reqIn    = req;
    wreadyIn = wready;
    flushIn  = flush;
    rstIn    = reset;
    depthIn  = DepthW'(depth);
    for (int i = 0; i < NumReq; i++) dataIn[i*Width +: Width] = reqData[i];
    #1;
    grantedIdx = modelGrant(req, wready, flush, reset, depth);
    checkOutput(grantedIdx);
    if (clrOut) clrCount++;
    advanceModel(grantedIdx, wready, flush, reset);
  endtask

  // Monitor: every accepted beat must be the oldest granted beat still outstanding.
  initial begin
    logic [Width-1:0] expBeat;
    forever begin
      @(negedge clk);
      #2;
      if (!rstIn && wvalidOut && wreadyIn) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL beat: got %0h expected none at %0t", wdataOut, $time);
        end else begin
          expBeat = expQ.pop_front();
          if (wdataOut !== expBeat) begin
            errors++;
            $display("[TB] FAIL beat: got %0h expected %0h at %0t", wdataOut, expBeat, $time);
          end
        end
      end
    end
  end

  initial begin
    rstIn    = 1'b1;
    reqIn    = '0;
    dataIn   = '0;
    wreadyIn = 1'b1;
    flushIn  = 1'b0;
    depthIn  = '0;
    mLast    = NumReq - 1;
    mPhase   = 0;
    mHeld    = 1'b0;
    mPend    = 1'b0;
    clrCount = 0;
    for (int i = 0; i < NumReq; i++) begin
      reqData[i]   = Width'(8'hA0 + i);
      reqActive[i] = 1'b0;
    end

    $display("[TB] reset and rotation");
    applyStimulus('0, 1, 0, 1, 0);
    applyStimulus('0, 1, 0, 1, 0);
    applyStimulus('0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 1, 0, 0, 0);
    applyStimulus('0, 1, 0, 0, 0);
    applyStimulus('0, 1, 0, 0, 0);

    $display("[TB] backpressure");
    applyStimulus('0, 1, 0, 1, 0);
    applyStimulus(4'b0101, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 0, 0, 0, 0);
    applyStimulus(4'b0100, 1, 0, 0, 0);
    applyStimulus('0, 1, 0, 0, 0);

    $display("[TB] flush with held beat");
    applyStimulus(4'b0001, 0, 0, 0, 0);
    applyStimulus(4'b0010, 0, 1, 0, 0);
    applyStimulus(4'b0010, 0, 0, 0, 0);
    applyStimulus(4'b0010, 0, 0, 0, 0);
    applyStimulus(4'b0010, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0010, 1, 0, 0, 0);
    applyStimulus('0, 1, 0, 0, 0);

    $display("[TB] coalesced second flush");
    clrCount = 0;
    applyStimulus('0, 1, 1, 0, 0);
    applyStimulus('0, 1, 0, 0, 0);
    applyStimulus('0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus('0, 1, 0, 0, 0);
    checkField("clrPulses", 32'(clrCount), 32'd2);

    $display("[TB] reset during drain");
    applyStimulus(4'b0001, 0, 0, 0, 0);
    applyStimulus('0, 0, 1, 0, 0);
    applyStimulus('0, 0, 0, 0, 0);
    applyStimulus('0, 0, 0, 1, 0);
    applyStimulus(4'b1001, 1, 0, 0, 0);
    applyStimulus('0, 1, 0, 0, 0);

`ifdef FIFO_ARB_RESERVE_EN
    $display("[TB] reserve slot");
    applyStimulus(4'b0110, 1, 0, 0, 3);
    applyStimulus(4'b0111, 1, 0, 0, 3);
    applyStimulus('0, 1, 0, 0, 0);
`endif

    $display("[TB] random traffic");
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [NumReq-1:0] req;
      for (int i = 0; i < NumReq; i++) begin
        if (!reqActive[i] && ($urandom % 2 == 0)) begin
          reqActive[i] = 1'b1;
          reqData[i]   = Width'($urandom);
        end
        req[i] = reqActive[i];
      end
      applyStimulus(req, ($urandom % 4) != 0, ($urandom % 25) == 0,
                    ($urandom % 300) == 0, int'($urandom_range(0, Depth)));
      if (grantedIdx >= 0) reqActive[grantedIdx] = 1'b0;
    end

    for (int i = 0; i < 20 && expQ.size() != 0; i++) applyStimulus('0, 1, 0, 0, 0);
    @(negedge clk);
    #3;
    checkField("drainEmpty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
